operand_collector: RTL



---
 rtl/bgpu_pkg.sv | 20 ++
 rtl/operand_collector.sv | 124 ++++++++++++
 2 files changed

// File: rtl/bgpu_pkg.sv
// bgpu_pkg: shared BGPU types for the instruction word, collector state and warp operand data.
package bgpu_pkg;

    localparam int unsigned BgpuWarpWidth = 32;
    localparam int unsigned BgpuRegWidth  = 32;

    typedef struct packed {
        logic [5:0] opcode;
        logic [1:0] fmt;
    } bgpu_inst_t;

    typedef enum logic [1:0] {
        OPC_IDLE,
        OPC_COLLECT,
        OPC_ISSUE
    } opc_state_e;

    typedef logic [BgpuWarpWidth*BgpuRegWidth-1:0] warp_data_t;

endpackage

// File: rtl/operand_collector.sv
// operand_collector: buffers one dispatched instruction, reads its source registers, then issues it.
//   clk_i / rst_i                 clock, asynchronous active-high reset
//   opc_ready_o                   a dispatch may be accepted this cycle
//   disp_*                        dispatched instruction fields (valid/tag/pc/mask/inst/dst/operands)
//   rf_req_* / rf_rsp_*           register-file read request channel and read data return
//   eu_*                          collected instruction toward the execution unit
module operand_collector
    import bgpu_pkg::*;
#(
    parameter int unsigned PcWidth         = 32,
    parameter int unsigned WarpWidth       = BgpuWarpWidth,
    parameter int unsigned NumTags         = 8,
    parameter int unsigned RegIdxWidth     = 6,
    parameter int unsigned OperandsPerInst = 2,
    parameter int unsigned RegWidth        = BgpuRegWidth,
    localparam int unsigned TagWidth       = $clog2(NumTags),
    localparam int unsigned OpIdxWidth     = (OperandsPerInst > 1) ? $clog2(OperandsPerInst) : 1
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_i,
    output logic                                                 opc_ready_o,
    input  logic                                                 disp_valid_i,
    input  logic [TagWidth-1:0]                                  disp_tag_i,
    input  logic [PcWidth-1:0]                                   disp_pc_i,
    input  logic [WarpWidth-1:0]                                 disp_act_mask_i,
    input  bgpu_inst_t                                           disp_inst_i,
    input  logic [RegIdxWidth-1:0]                               disp_dst_i,
    input  logic [OperandsPerInst-1:0][RegIdxWidth-1:0]          disp_operands_i,
    output logic                                                 rf_req_valid_o,
    input  logic                                                 rf_req_ready_i,
    output logic [RegIdxWidth-1:0]                               rf_req_reg_o,
    output logic [OpIdxWidth-1:0]                                rf_req_operand_o,
    input  logic                                                 rf_rsp_valid_i,
    input  logic [OpIdxWidth-1:0]                                rf_rsp_operand_i,
    input  logic [WarpWidth*RegWidth-1:0]                        rf_rsp_data_i,
    input  logic                                                 eu_ready_i,
    output logic                                                 eu_valid_o,
    output logic [TagWidth-1:0]                                  eu_tag_o,
    output logic [PcWidth-1:0]                                   eu_pc_o,
    output logic [WarpWidth-1:0]                                 eu_act_mask_o,
    output bgpu_inst_t                                           eu_inst_o,
    output logic [RegIdxWidth-1:0]                               eu_dst_o,
    output logic [OperandsPerInst-1:0][WarpWidth*RegWidth-1:0]   eu_operands_o
);

    opc_state_e                                          r_state;
    logic [TagWidth-1:0]                                 r_tag;
    logic [PcWidth-1:0]                                  r_pc;
    logic [WarpWidth-1:0]                                r_mask;
    bgpu_inst_t                                          r_inst;
    logic [RegIdxWidth-1:0]                              r_dst;
    logic [OperandsPerInst-1:0][RegIdxWidth-1:0]         r_src;
    logic [OperandsPerInst-1:0][WarpWidth*RegWidth-1:0]  r_data;
    logic [OperandsPerInst-1:0]                          r_req_pending;
    logic [OperandsPerInst-1:0]                          r_data_pending;

    logic                        w_accept;
    logic                        w_req_fire;
    logic [OpIdxWidth-1:0]       w_req_op;
    logic [OperandsPerInst-1:0]  w_rsp_mask;

    // Lowest pending slot wins: scanning downward lets the last hit be the lowest index.
    always_comb begin
        w_req_op = '0;
        for (int i = OperandsPerInst - 1; i >= 0; i--)
            if (r_req_pending[i]) w_req_op = OpIdxWidth'(i);
    end

    // A response only counts for a slot still waiting on data; anything else is dropped.
    assign w_rsp_mask = (r_state == OPC_COLLECT && rf_rsp_valid_i)
                      ? ((OperandsPerInst'(1) << rf_rsp_operand_i) & r_data_pending) : '0;

    assign opc_ready_o      = (r_state == OPC_IDLE) || (r_state == OPC_ISSUE && eu_ready_i);
    assign w_accept         = disp_valid_i && opc_ready_o;
    assign rf_req_valid_o   = (r_state == OPC_COLLECT) && |r_req_pending;
    assign rf_req_operand_o = w_req_op;
    assign rf_req_reg_o     = r_src[w_req_op];
    assign w_req_fire       = rf_req_valid_o && rf_req_ready_i;

    assign eu_valid_o    = (r_state == OPC_ISSUE);
    assign eu_tag_o      = r_tag;
    assign eu_pc_o       = r_pc;
    assign eu_act_mask_o = r_mask;
    assign eu_inst_o     = r_inst;
    assign eu_dst_o      = r_dst;
    assign eu_operands_o = r_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= OPC_IDLE;
            r_tag          <= '0;
            r_pc           <= '0;
            r_mask         <= '0;
            r_inst         <= '0;
            r_dst          <= '0;
            r_src          <= '0;
            r_data         <= '0;
            r_req_pending  <= '0;
            r_data_pending <= '0;
        end else if (w_accept) begin
            // Covers both IDLE and the zero-bubble ISSUE hand-off.
            r_state        <= OPC_COLLECT;
            r_tag          <= disp_tag_i;
            r_pc           <= disp_pc_i;
            r_mask         <= disp_act_mask_i;
            r_inst         <= disp_inst_i;
            r_dst          <= disp_dst_i;
            r_src          <= disp_operands_i;
            r_req_pending  <= '1;
            r_data_pending <= '1;
        end else if (r_state == OPC_ISSUE && eu_ready_i) begin
            r_state <= OPC_IDLE;
        end else if (r_state == OPC_COLLECT) begin
            if (w_req_fire) r_req_pending[w_req_op] <= 1'b0;
            if (|w_rsp_mask) begin
                r_data[rf_rsp_operand_i]         <= rf_rsp_data_i;
                r_data_pending[rf_rsp_operand_i] <= 1'b0;
            end
            // Move on in the same edge that retires the final outstanding operand.
            if ((r_data_pending & ~w_rsp_mask) == '0) r_state <= OPC_ISSUE;
        end
    end

endmodule
